// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types used by the fetch-stage direction predictor.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    localparam lc3b_opcode op_br = 4'b0000;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } lc3b_bht_ctr;

endpackage

// File: rtl/bht_counter.sv
// Combinational next-state for a 2-bit saturating branch history counter.
module bht_counter
    import lc3b_types::*;
(
    input  lc3b_bht_ctr ctr,
    input  logic        taken,
    output lc3b_bht_ctr next_ctr
);

    always_comb begin
        next_ctr = ctr;
        case (ctr)
            STRONG_NT: next_ctr = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   next_ctr = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    next_ctr = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  next_ctr = taken ? STRONG_T : WEAK_T;
            default:   next_ctr = WEAK_NT;
        endcase
    end

endmodule

// File: rtl/branch_dir_predictor.sv
// Gshare direction predictor: PC XOR global history indexes 2-bit counters,
// trained non-speculatively from write-back, with saturating perf counts.
module branch_dir_predictor
    import lc3b_types::*;
#(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned HIST_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  lc3b_word              pc_if,
    input  logic                  stall_if,
    input  lc3b_word              pc_wb,
    input  lc3b_opcode            opcode_wb,
    input  logic                  is_valid_inst_wb,
    input  logic                  br_taken_wb,
    input  logic                  pred_taken_wb,
    input  logic [INDEX_BITS-1:0] pred_index_wb,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    output logic                  mispredict_wb,
    output logic [15:0]           branch_count,
    output logic [15:0]           mispredict_count
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    lc3b_bht_ctr           table_q [DEPTH];
    lc3b_bht_ctr           table_d [DEPTH];
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic [15:0]           branch_count_q, branch_count_d;
    logic [15:0]           mispredict_count_q, mispredict_count_d;

    logic                  update;
    logic [INDEX_BITS-1:0] fetch_index;
    lc3b_bht_ctr           fetch_ctr;
    lc3b_bht_ctr           wr_ctr;
    lc3b_bht_ctr           wr_next;

    // pc_wb is kept on the port for debug visibility only.
    logic unused_pc;
    assign unused_pc = ^{pc_wb, pc_if[15:INDEX_BITS+1], pc_if[0]};

    assign update        = is_valid_inst_wb && (opcode_wb == op_br);
    assign mispredict_wb = update && (pred_taken_wb != br_taken_wb);
    assign fetch_index   = pc_if[INDEX_BITS:1] ^ INDEX_BITS'(ghr_q);
    assign fetch_ctr     = table_q[fetch_index];
    assign wr_ctr        = table_q[pred_index_wb];

    bht_counter u_wr_ctr (
        .ctr      (wr_ctr),
        .taken    (br_taken_wb),
        .next_ctr (wr_next)
    );

    // Fetch reads the pre-update table and GHR; no write-to-read bypass.
    always_comb begin
        table_d            = table_q;
        ghr_d              = ghr_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        pred_taken_d       = pred_taken_q;
        pred_index_d       = pred_index_q;

        if (!stall_if) begin
            pred_index_d = fetch_index;
            pred_taken_d = fetch_ctr[1];
        end

        if (update) begin
            table_d[pred_index_wb] = wr_next;
            ghr_d = (ghr_q << 1) | HIST_BITS'(br_taken_wb);
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + 16'd1;
            end
            if (mispredict_wb && (mispredict_count_q != '1)) begin
                mispredict_count_d = mispredict_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= WEAK_NT;
            end
            ghr_q              <= '0;
            pred_taken_q       <= 1'b0;
            pred_index_q       <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            table_q            <= table_d;
            ghr_q              <= ghr_d;
            pred_taken_q       <= pred_taken_d;
            pred_index_q       <= pred_index_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign pred_taken       = pred_taken_q;
    assign pred_index       = pred_index_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_dir_predictor.sv
// Scoreboard bench for branch_dir_predictor against an array/integer gshare model.
module tb_branch_dir_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_if;
    logic        stall_if;
    logic [15:0] pc_wb;
    logic [3:0]  opcode_wb;
    logic        is_valid_inst_wb;
    logic        br_taken_wb;
    logic        pred_taken_wb;
    logic [4:0]  pred_index_wb;
    logic        pred_taken;
    logic [4:0]  pred_index;
    logic        mispredict_wb;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    always #5 clk = ~clk;

    branch_dir_predictor #(.INDEX_BITS(5), .HIST_BITS(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_if            (pc_if),
        .stall_if         (stall_if),
        .pc_wb            (pc_wb),
        .opcode_wb        (opcode_wb),
        .is_valid_inst_wb (is_valid_inst_wb),
        .br_taken_wb      (br_taken_wb),
        .pred_taken_wb    (pred_taken_wb),
        .pred_index_wb    (pred_index_wb),
        .pred_taken       (pred_taken),
        .pred_index       (pred_index),
        .mispredict_wb    (mispredict_wb),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        logic        pt;
        logic [4:0]  idx;
        logic        misp;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    // Reference model: counters as integers 0..3, history as an integer mod 32.
    int tbl[32];
    int ghr;
    int bc, mc;
    int m_idx;
    bit m_pt;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) tbl[i] = 1;
        ghr = 0; bc = 0; mc = 0; m_idx = 0; m_pt = 0;
    endtask

    task automatic step(input logic [15:0] pc, input logic stall, input logic valid,
                        input logic [3:0] opc, input logic taken, input logic ptaken,
                        input logic [4:0] pidx);
        exp_t e;
        bit upd;
        @(negedge clk);
        pc_if = pc; stall_if = stall; is_valid_inst_wb = valid; opcode_wb = opc;
        br_taken_wb = taken; pred_taken_wb = ptaken; pred_index_wb = pidx;
        pc_wb = $urandom;
        upd = valid && (opc == 4'd0);
        if (!stall) begin
            m_idx = ((int'(pc) / 2) % 32) ^ ghr;
            m_pt  = (tbl[m_idx] >= 2);
        end
        e.misp = upd && (ptaken != taken);
        if (upd) begin
            if (taken) tbl[pidx] = (tbl[pidx] == 3) ? 3 : tbl[pidx] + 1;
            else       tbl[pidx] = (tbl[pidx] == 0) ? 0 : tbl[pidx] - 1;
            ghr = (ghr * 2 + int'(taken)) % 32;
            if (bc < 65535) bc++;
            if (e.misp && mc < 65535) mc++;
        end
        e.pt = m_pt; e.idx = 5'(m_idx); e.bc = 16'(bc); e.mc = 16'(mc);
        exp_q.push_back(e);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        is_valid_inst_wb = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_pred_taken", int'(pred_taken), 0);
        check("rst_pred_index", int'(pred_index), 0);
        check("rst_branch_count", int'(branch_count), 0);
        check("rst_mispredict_count", int'(mispredict_count), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every edge after a driven cycle, compare DUT outputs against the queue head.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pred_taken", int'(pred_taken), int'(e.pt));
                check("pred_index", int'(pred_index), int'(e.idx));
                check("mispredict_wb", int'(mispredict_wb), int'(e.misp));
                check("branch_count", int'(branch_count), int'(e.bc));
                check("mispredict_count", int'(mispredict_count), int'(e.mc));
            end
        end
    end

    initial begin
        rst = 1'b1; pc_if = '0; stall_if = 1'b0; pc_wb = '0; opcode_wb = 4'hF;
        is_valid_inst_wb = 1'b0; br_taken_wb = 1'b0; pred_taken_wb = 1'b0; pred_index_wb = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        step(16'h0040, 0, 0, 4'h0, 0, 0, 5'd0);
        // Training at index 3; fetch 0x0006 maps to index 3 while ghr stays 0 only until first update.
        step(16'h0006, 0, 1, 4'h0, 1, 0, 5'd3);
        step(16'h0006, 0, 1, 4'h0, 1, 1, 5'd3);
        for (int k = 0; k < 4; k++) step(16'h0006, 0, 1, 4'h0, 0, 1, 5'd3);
        step(16'h0006, 0, 0, 4'h0, 0, 0, 5'd0);

        reset_mid();
        // History 1,0,1 then fetch 0x0014 -> index 01010 ^ 00101 = 01111.
        step(16'h0000, 0, 1, 4'h0, 1, 0, 5'd9);
        step(16'h0000, 0, 1, 4'h0, 0, 0, 5'd9);
        step(16'h0000, 0, 1, 4'h0, 1, 0, 5'd9);
        step(16'h0014, 0, 0, 4'h0, 0, 0, 5'd0);

        reset_mid();
        // Same-edge hazard at index 5 (pc 0x000A), then stall with concurrent update.
        step(16'h000A, 0, 1, 4'h0, 1, 0, 5'd5);
        step(16'h000A, 0, 0, 4'h0, 0, 0, 5'd0);
        step(16'h0020, 1, 1, 4'h0, 1, 0, 5'd7);
        step(16'h0030, 1, 1, 4'h0, 1, 0, 5'd7);
        step(16'h0044, 1, 0, 4'h1, 1, 1, 5'd7);
        step(16'h0000, 0, 0, 4'h0, 0, 0, 5'd0);
        // Non-BR and invalid slots do not count.
        step(16'h0002, 0, 1, 4'h1, 0, 1, 5'd1);
        step(16'h0002, 0, 0, 4'h0, 0, 1, 5'd1);
        step(16'h0002, 0, 1, 4'h0, 0, 1, 5'd1);

        for (int n = 0; n < 2000; n++) begin
            logic [4:0] pidx;
            pidx = ($urandom_range(0, 1) == 1) ? 5'(m_idx) : 5'($urandom_range(0, 7));
            step(16'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 6) ? 4'h0 : 4'($urandom),
                 1'($urandom), 1'($urandom), pidx);
        end

        reset_mid();
        for (int n = 0; n < 65540; n++) step(16'($urandom), 0, 1, 4'h0, 0, 1, 5'($urandom));

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        done = 1;
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
